uart_alu_interface: RTL and testbench

Sequencer between the UART receiver/transmitter and the ALU inside the UART top block. It gathers three received bytes in order (operand A, operand B, opcode) and presents them to the combinational ALU. It then captures the ALU result and hands it to the UART transmitter as one byte. It waits for transmit completion before accepting the next frame.

---
 rtl/uart_alu_interface.sv | 198 +++++++++++++++++++
 tb/tb_uart_alu_interface.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_interface.sv
// -----------------------------------------------------------------------------
// uart_alu_interface
//
// Sequencer between the UART receiver/transmitter and a combinational ALU.
// Collects three received bytes (operand A, operand B, opcode), lets the ALU
// settle for one cycle on the registered operands, captures the result and
// hands it to the transmitter as a single byte, then waits for the
// transmitter's done pulse before accepting the next frame.
//
// Ports:
//   i_clock       system clock, rising edge
//   i_reset       asynchronous, active-low reset
//   i_rx_data     received byte, valid with i_rx_done
//   i_rx_done     one-cycle "byte available" pulse from the receiver
//   i_alu_result  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
//   i_tx_done     one-cycle "stop bit sent" pulse from the transmitter
//   o_alu_a       registered operand A
//   o_alu_b       registered operand B
//   o_alu_op      registered opcode (low OPW bits of the third byte)
//   o_tx_data     registered result byte for the transmitter
//   o_tx_start    one-cycle transmit start pulse (high during SEND)
//   o_busy        high from EXEC through WAIT_DONE
//   o_drop        one-cycle pulse: a byte arrived while busy and was discarded
//   o_timeout     one-cycle pulse: a partial frame was abandoned
// -----------------------------------------------------------------------------
module uart_alu_interface #(
  parameter int DBIT    = 8,
  parameter int OPW     = 6,
  parameter int TIMEOUT = 0,
  parameter int TOW     = 32
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [DBIT-1:0] i_rx_data,
  input  logic            i_rx_done,
  input  logic [DBIT-1:0] i_alu_result,
  input  logic            i_tx_done,
  output logic [DBIT-1:0] o_alu_a,
  output logic [DBIT-1:0] o_alu_b,
  output logic [OPW-1:0]  o_alu_op,
  output logic [DBIT-1:0] o_tx_data,
  output logic            o_tx_start,
  output logic            o_busy,
  output logic            o_drop,
  output logic            o_timeout
);

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND,
    S_WAIT_DONE
  } state_e;

  // Last counter value before the partial frame is abandoned. With the
  // timeout disabled this is 0, which also freezes the counter at 0.
  localparam logic [TOW-1:0] TO_LAST = (TIMEOUT > 0) ? TOW'(TIMEOUT - 1) : '0;
  localparam bit             TO_EN   = (TIMEOUT > 0);

  state_e          state_q,    state_d;
  logic [DBIT-1:0] alu_a_q,    alu_a_d;
  logic [DBIT-1:0] alu_b_q,    alu_b_d;
  logic [OPW-1:0]  alu_op_q,   alu_op_d;
  logic [DBIT-1:0] tx_data_q,  tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            drop_q,     drop_d;
  logic            timeout_q,  timeout_d;
  logic [TOW-1:0]  cnt_q,      cnt_d;

  logic busy;
  logic expire;

  assign busy   = (state_q == S_EXEC) || (state_q == S_SEND) ||
                  (state_q == S_WAIT_DONE);
  assign expire = TO_EN && (cnt_q == TO_LAST);

  // Saturating increment shared by both operand-wait states.
  function automatic logic [TOW-1:0] cnt_step(input logic [TOW-1:0] c);
    return (c == TO_LAST) ? c : c + TOW'(1);
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_WAIT_A: begin
        cnt_d = '0;
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = S_WAIT_B;
        end
      end

      S_WAIT_B: begin
        // A byte arriving on the expiry cycle takes priority over the timeout.
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          cnt_d   = '0;
          state_d = S_WAIT_OP;
        end else if (expire) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT_A;
        end else begin
          cnt_d = cnt_step(cnt_q);
        end
      end

      S_WAIT_OP: begin
        if (i_rx_done) begin
          alu_op_d = i_rx_data[OPW-1:0];
          cnt_d    = '0;
          state_d  = S_EXEC;
        end else if (expire) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT_A;
        end else begin
          cnt_d = cnt_step(cnt_q);
        end
      end

      S_EXEC: begin
        // Operands have been stable for a full cycle; capture the ALU output
        // and raise tx_start so it is high for exactly the SEND cycle.
        tx_data_d  = i_alu_result;
        tx_start_d = 1'b1;
        state_d    = S_SEND;
      end

      S_SEND: begin
        state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (i_tx_done) begin
          cnt_d   = '0;
          state_d = S_WAIT_A;
        end
      end

      default: begin
        state_d = S_WAIT_A;
      end
    endcase

    // Any byte seen while busy is discarded, including one that coincides
    // with i_tx_done: a new frame never starts on the done cycle.
    drop_d = i_rx_done && busy;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      drop_q     <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      drop_q     <= drop_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy;
  assign o_drop     = drop_q;
  assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// -----------------------------------------------------------------------------
// tb_uart_alu_interface
//
// Directed bench for uart_alu_interface (TIMEOUT=100). A small combinational
// ALU model closes the loop between the operand outputs and i_alu_result.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_uart_alu_interface;

  localparam int DBIT    = 8;
  localparam int OPW     = 6;
  localparam int TIMEOUT = 100;
  localparam int TOW     = 32;

  logic            clk;
  logic            rst_n;
  logic [DBIT-1:0] rx_data;
  logic            rx_done;
  logic [DBIT-1:0] alu_result;
  logic            tx_done;
  logic [DBIT-1:0] alu_a;
  logic [DBIT-1:0] alu_b;
  logic [OPW-1:0]  alu_op;
  logic [DBIT-1:0] tx_data;
  logic            tx_start;
  logic            busy;
  logic            drop;
  logic            timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_alu_interface #(
    .DBIT    (DBIT),
    .OPW     (OPW),
    .TIMEOUT (TIMEOUT),
    .TOW     (TOW)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_alu_result (alu_result),
    .i_tx_done    (tx_done),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_drop       (drop),
    .o_timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, anything else 0.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      6'h24:   alu_result = alu_a & alu_b;
      6'h25:   alu_result = alu_a | alu_b;
      default: alu_result = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  // Sends the opcode byte and checks the EXEC/SEND/WAIT_DONE timeline.
  // With do_done=0 the DUT is left in WAIT_DONE.
  task automatic finish_op(input string tag, input logic [7:0] op_byte,
                           input logic [5:0] exp_op, input logic [7:0] exp_res,
                           input bit do_done);
    send_byte(op_byte);
    check({tag, "_op"}, alu_op, exp_op);
    check({tag, "_exec_start"}, tx_start, 0);
    check({tag, "_exec_busy"}, busy, 1);
    tick();
    check({tag, "_send_start"}, tx_start, 1);
    check({tag, "_send_data"}, tx_data, exp_res);
    tick();
    check({tag, "_wd_start"}, tx_start, 0);
    check({tag, "_wd_busy"}, busy, 1);
    tick();
    tick();
    check({tag, "_wd_hold"}, tx_data, exp_res);
    if (do_done) begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check({tag, "_idle"}, busy, 0);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] op_byte,
                           input logic [5:0] exp_op, input logic [7:0] exp_res,
                           input bit do_done);
    send_byte(a);
    check({tag, "_a"}, alu_a, a);
    check({tag, "_a_busy"}, busy, 0);
    send_byte(b);
    check({tag, "_b"}, alu_b, b);
    finish_op(tag, op_byte, exp_op, exp_res, do_done);
  endtask

  initial begin
    int early;

    rst_n   = 1'b0;
    rx_data = '0;
    rx_done = 1'b0;
    tx_done = 1'b0;

    // Reset state
    #1;
    check("rst_a", alu_a, 0);
    check("rst_b", alu_b, 0);
    check("rst_op", alu_op, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_flags", {tx_start, busy, drop, timeout}, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // i_tx_done outside WAIT_DONE is ignored
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("txd_ignored_busy", busy, 0);
    check("txd_ignored_start", tx_start, 0);

    // Basic ADD: 0x14 + 0x07 = 0x1B
    run_frame("add", 8'h14, 8'h07, 8'h20, 6'h20, 8'h1B, 1'b1);

    // Back-to-back: SUB then OR (opcode byte 0xE5 -> upper bits ignored)
    run_frame("sub", 8'h14, 8'h07, 8'h22, 6'h22, 8'h0D, 1'b1);
    run_frame("or", 8'hF0, 8'h0F, 8'hE5, 6'h25, 8'hFF, 1'b0);

    // Drop while busy: state and operands unchanged
    send_byte(8'h55);
    check("drop_pulse", drop, 1);
    check("drop_busy", busy, 1);
    check("drop_a_kept", alu_a, 8'hF0);
    tick();
    check("drop_one_cycle", drop, 0);

    // rx_done and tx_done together in WAIT_DONE: done wins, byte dropped
    rx_data = 8'h66;
    rx_done = 1'b1;
    tx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tx_done = 1'b0;
    check("race_done_drop", drop, 1);
    check("race_done_idle", busy, 0);
    check("race_done_a_kept", alu_a, 8'hF0);
    tick();
    check("race_done_drop_end", drop, 0);

    // Next frame starts cleanly: AND 0x3C & 0x0F = 0x0C
    run_frame("after_drop", 8'h3C, 8'h0F, 8'h24, 6'h24, 8'h0C, 1'b1);
    check("after_drop_no_drop", drop, 0);

    // Timeout: only A sent, expiry on the 100th edge after capture
    send_byte(8'h14);
    early = 0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      if (timeout) early++;
    end
    check("to_not_early", early, 0);
    tick();
    check("to_pulse", timeout, 1);
    check("to_a_kept", alu_a, 8'h14);
    tick();
    check("to_one_cycle", timeout, 0);
    run_frame("to_next", 8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 1'b1);

    // Timeout/byte race: B arrives exactly on the expiry cycle
    send_byte(8'h14);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    send_byte(8'h07);
    check("race_to_none", timeout, 0);
    check("race_to_b", alu_b, 8'h07);
    for (int i = 0; i < 50; i++) tick();
    check("race_to_wait_op", {timeout, busy}, 0);
    finish_op("race_to", 8'h22, 6'h22, 8'h0D, 1'b1);

    // Async reset in WAIT_DONE, between edges
    run_frame("pre_rst", 8'h14, 8'h07, 8'h20, 6'h20, 8'h1B, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_a", alu_a, 0);
    check("arst_b", alu_b, 0);
    check("arst_op", alu_op, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_flags", {tx_start, busy, drop, timeout}, 0);
    tick();
    rst_n = 1'b1;
    run_frame("post_rst", 8'h14, 8'h07, 8'h20, 6'h20, 8'h1B, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
